// File: rtl/ex_trap_arb.sv
// ex_trap_arb: synchronises N interrupt lines, records pending requests (edge or level
// per source) and presents one winner on a valid/ready trap port. Define EX_TRAP_RR_EN for round-robin.
module ex_trap_arb #(
   parameter int                 SRC_NUM   = 8,
   parameter logic [SRC_NUM-1:0] EDGE_MASK = {SRC_NUM{1'b1}},
   parameter int                 ID_W      = $clog2(SRC_NUM)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [SRC_NUM-1:0] src_i,
   input  logic [SRC_NUM-1:0] src_en,
   input  logic               pend_clr,
   output logic               trap_valid,
   input  logic               trap_ready,
   output logic [ID_W-1:0]    trap_id,
   output logic [SRC_NUM-1:0] pending,
   output logic               edge_lost
);

   typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

   state_t             state_q, state_d;
   logic [SRC_NUM-1:0] s1_q, s2_q, s3_q;
   logic [SRC_NUM-1:0] pending_q, pending_d;
   logic               edge_lost_q, edge_lost_d;
   logic               trap_valid_q, trap_valid_d;
   logic [ID_W-1:0]    trap_id_q, trap_id_d;
   logic [SRC_NUM-1:0] rise, set_vec, clr_mask, req;
   logic               accept;
   logic [ID_W-1:0]    win_id;

   assign rise    = s2_q & ~s3_q & EDGE_MASK;
   assign set_vec = rise | (s2_q & ~EDGE_MASK);
   assign accept  = trap_valid_q & trap_ready;
   // Masked sources keep their pending bit; src_en only gates arbitration.
   assign req     = pending_q & src_en;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q <= '0;
         s2_q <= '0;
         s3_q <= '0;
      end else begin
         // NOTE: non-blocking so every flop samples the pre-edge value of its neighbour.
         s1_q <= src_i;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   always_comb begin
      // NOTE: every output gets a default first so no path infers a latch.
      clr_mask = '0;
      if (accept) clr_mask[trap_id_q] = 1'b1;
      if (pend_clr) clr_mask = '1;
      pending_d   = (pending_q & ~clr_mask) | set_vec;
      edge_lost_d = (edge_lost_q & ~pend_clr) | (|(rise & pending_q & ~clr_mask));
   end

`ifdef EX_TRAP_RR_EN
   logic [ID_W-1:0]    last_q, last_d;
   logic [SRC_NUM-1:0] rot;
   int                 rr_start, rr_pick;

   always_comb begin
      last_d   = accept ? trap_id_q : last_q;
      rr_start = (int'(last_q) + 1) % SRC_NUM;
      rot      = (req >> rr_start) | (req << (SRC_NUM - rr_start));
      rr_pick  = 0;
      for (int i = SRC_NUM - 1; i >= 0; i--) begin
         if (rot[i]) rr_pick = i;
      end
      win_id = ID_W'((rr_start + rr_pick) % SRC_NUM);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) last_q <= ID_W'(SRC_NUM - 1);
      else        last_q <= last_d;
   end
`else
   always_comb begin
      win_id = '0;
      for (int i = SRC_NUM - 1; i >= 0; i--) begin
         if (req[i]) win_id = ID_W'(i);
      end
   end
`endif

   // Once in REQ the request is held until accepted, whatever happens to pending/src_en.
   always_comb begin
      state_d      = state_q;
      trap_valid_d = trap_valid_q;
      trap_id_d    = trap_id_q;
      case (state_q)
         IDLE: begin
            if (|req) begin
               state_d      = REQ;
               trap_valid_d = 1'b1;
               trap_id_d    = win_id;
            end
         end
         REQ: begin
            if (trap_ready) begin
               state_d      = GAP;
               trap_valid_d = 1'b0;
            end
         end
         GAP:     state_d = IDLE;
         default: begin
            state_d      = IDLE;
            trap_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         trap_valid_q <= 1'b0;
         trap_id_q    <= '0;
         pending_q    <= '0;
         edge_lost_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         trap_valid_q <= trap_valid_d;
         trap_id_q    <= trap_id_d;
         pending_q    <= pending_d;
         edge_lost_q  <= edge_lost_d;
      end
   end

   assign trap_valid = trap_valid_q;
   assign trap_id    = trap_id_q;
   assign pending    = pending_q;
   assign edge_lost  = edge_lost_q;

endmodule
